pid_sched: RTL

PID_SCHED -- requirements
Module: pid_sched

---
 rtl/pid_sched.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/pid_sched.sv
// pid_sched: power/soft-start/run sequencer for the balance PID.
// Holds inertial samples for the PID, issues the delayed integrator update
// strobe, drops samples that arrive while an update is in flight, runs a
// sample watchdog and debounces the rider-detect input.
module pid_sched #(
   parameter logic [15:0] TMO_CYC  = 16'd4096,
   parameter logic [7:0]  DBNC_CYC = 8'd200
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        inert_vld,
   input  logic [15:0] ptch,
   input  logic [15:0] ptch_rt,
   input  logic        pwr_btn,
   input  logic        rider_present,
   input  logic [7:0]  ss_tmr,
   output logic [15:0] ptch_q,
   output logic [15:0] ptch_rt_q,
   output logic        pid_vld,
   output logic        pwr_up,
   output logic        rider_off,
   output logic        tmo_flt,
   output logic [7:0]  drop_cnt,
   output logic [1:0]  state
);

   typedef enum logic [1:0] {
      ST_OFF   = 2'd0,
      ST_SOFT  = 2'd1,
      ST_RUN   = 2'd2,
      ST_FAULT = 2'd3
   } state_t;

   state_t      state_r;
   state_t      state_nxt_s;

   logic [15:0] wd_cnt_r;
   logic [7:0]  db_cnt_r;
   logic [7:0]  db_nxt_s;
   logic        stg1_r;        // capture done last cycle, strobe due next cycle
   logic [15:0] ptch_q_r;
   logic [15:0] ptch_rt_q_r;
   logic        pid_vld_r;
   logic        pwr_up_r;
   logic        rider_off_r;
   logic        tmo_flt_r;
   logic [7:0]  drop_cnt_r;

   logic        wd_exp_s;
   logic        act_s;
   logic        act_nxt_s;
   logic        busy_s;
   logic        cap_s;
   logic        drop_s;

   // Next-state logic; power-off requests always win over other transitions.
   always_comb begin
      state_nxt_s = state_r;
      wd_exp_s    = (wd_cnt_r == (TMO_CYC - 16'd1)) && !inert_vld;
      case (state_r)
         ST_OFF: begin
            if (pwr_btn) state_nxt_s = ST_SOFT;
            else         state_nxt_s = ST_OFF;
         end
         ST_SOFT: begin
            if (!pwr_btn)              state_nxt_s = ST_OFF;
            else if (ss_tmr == 8'hFF)  state_nxt_s = ST_RUN;
            else                       state_nxt_s = ST_SOFT;
         end
         ST_RUN: begin
            if (!pwr_btn)      state_nxt_s = ST_OFF;
            else if (wd_exp_s) state_nxt_s = ST_FAULT;
            else               state_nxt_s = ST_RUN;
         end
         ST_FAULT: begin
            if (!pwr_btn) state_nxt_s = ST_OFF;
            else          state_nxt_s = ST_FAULT;
         end
         default: state_nxt_s = ST_OFF;
      endcase
   end

   // Sample acceptance: captures only when active and no update is pending.
   always_comb begin
      act_s     = (state_r == ST_SOFT) || (state_r == ST_RUN);
      act_nxt_s = (state_nxt_s == ST_SOFT) || (state_nxt_s == ST_RUN);
      busy_s    = stg1_r || pid_vld_r;
      cap_s     = act_s && inert_vld && !busy_s;
      drop_s    = act_s && inert_vld && busy_s;
   end

   // Debounce count for the next cycle: clears on rider loss, holds at limit.
   always_comb begin
      if (!rider_present)            db_nxt_s = 8'd0;
      else if (db_cnt_r == DBNC_CYC) db_nxt_s = db_cnt_r;
      else                           db_nxt_s = db_cnt_r + 8'd1;
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_r <= ST_OFF;
      else     state_r <= state_nxt_s;
   end

   // Watchdog: counts RUN cycles since entry or since the last sample.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                    wd_cnt_r <= 16'd0;
      else if (state_r != ST_RUN) wd_cnt_r <= 16'd0;
      else if (inert_vld)         wd_cnt_r <= 16'd0;
      else                        wd_cnt_r <= wd_cnt_r + 16'd1;
   end

   // Rider debounce counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) db_cnt_r <= 8'd0;
      else     db_cnt_r <= db_nxt_s;
   end

   // Held samples: loaded on capture, otherwise stable.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptch_q_r    <= 16'd0;
         ptch_rt_q_r <= 16'd0;
      end else if (cap_s) begin
         ptch_q_r    <= ptch;
         ptch_rt_q_r <= ptch_rt;
      end else begin
         ptch_q_r    <= ptch_q_r;
         ptch_rt_q_r <= ptch_rt_q_r;
      end
   end

   // Update strobe pipeline: one spare cycle after capture for the PID's
   // registered accumulator; cancelled if the FSM leaves SOFT/RUN meanwhile.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stg1_r    <= 1'b0;
         pid_vld_r <= 1'b0;
      end else begin
         stg1_r    <= cap_s && act_nxt_s;
         pid_vld_r <= stg1_r && act_nxt_s;
      end
   end

   // Saturating count of samples rejected during an in-flight update.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                  drop_cnt_r <= 8'd0;
      else if (drop_s && (drop_cnt_r != 8'hFF)) drop_cnt_r <= drop_cnt_r + 8'd1;
      else                                      drop_cnt_r <= drop_cnt_r;
   end

   // Registered status outputs, derived from next state so they align with it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pwr_up_r    <= 1'b0;
         tmo_flt_r   <= 1'b0;
         rider_off_r <= 1'b1;
      end else begin
         pwr_up_r    <= act_nxt_s;
         tmo_flt_r   <= (state_nxt_s == ST_FAULT);
         rider_off_r <= !((db_nxt_s == DBNC_CYC) && act_nxt_s);
      end
   end

   assign state     = state_r;
   assign ptch_q    = ptch_q_r;
   assign ptch_rt_q = ptch_rt_q_r;
   assign pid_vld   = pid_vld_r;
   assign pwr_up    = pwr_up_r;
   assign rider_off = rider_off_r;
   assign tmo_flt   = tmo_flt_r;
   assign drop_cnt  = drop_cnt_r;

endmodule
